detector_presenca_hcsr04: RTL and testbench

- Downstream consumer and scheduler for the HC-SR04 interface.
- Periodically pulses `medir` and waits for `pronto` with a timeout.
- Converts the 3-digit BCD `medida` (cm) to binary and keeps a 4-sample moving average.
- Drives a hysteretic cup-presence flag used by the coffee-machine control FSM.

---
 rtl/detector_presenca_hcsr04_pkg.sv | 25 ++
 rtl/detector_presenca_hcsr04_bcd3_para_binario.sv | 29 ++
 rtl/detector_presenca_hcsr04.sv | 183 ++++++++++++++++++
 tb/tb_detector_presenca_hcsr04.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/detector_presenca_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 presence detector: FSM state codes,
// datapath widths and the BCD digit limit.
package detector_presenca_hcsr04_pkg;

  localparam int ESTADO_W = 4;
  localparam int MEDIA_W  = 10;
  localparam int SOMA_W   = 12;
  localparam int N_AMOSTRAS = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL = 4'd0,
    PEDE    = 4'd1,
    AGUARDA = 4'd2,
    ACUMULA = 4'd3,
    AVALIA  = 4'd4,
    ESPERA  = 4'd5,
    ERRO    = 4'd7
  } estado_t;

  // A BCD digit is legal only in 0..9.
  function automatic logic digito_invalido(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/detector_presenca_hcsr04_bcd3_para_binario.sv
// Combinational 3-digit BCD to binary converter with an invalid-digit flag.
// Out-of-range digits still produce a (meaningless) binary value; callers
// must honour `invalido`.
module bcd3_para_binario
  import detector_presenca_hcsr04_pkg::*;
(
  input  logic [11:0]        bcd,
  output logic [MEDIA_W-1:0] binario,
  output logic               invalido
);

  logic [2:0] digito_ruim;

  // One range check per digit.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digito
      assign digito_ruim[gi] = digito_invalido(bcd[gi*4 +: 4]);
    end
  endgenerate

  // Weighted sum of hundreds, tens and units.
  always_comb begin
    invalido = |digito_ruim;
    binario  = MEDIA_W'(bcd[11:8]) * MEDIA_W'(100)
             + MEDIA_W'(bcd[7:4])  * MEDIA_W'(10)
             + MEDIA_W'(bcd[3:0]);
  end

endmodule

// File: rtl/detector_presenca_hcsr04.sv
// Scheduler and consumer for the HC-SR04 interface: periodic requests with
// timeout, BCD conversion, 4-sample moving average and hysteretic presence.
module detector_presenca_hcsr04
  import detector_presenca_hcsr04_pkg::*;
#(
  parameter int unsigned PERIODO      = 5000000,
  parameter int unsigned TIMEOUT      = 2500000,
  parameter int unsigned LIMIAR_PERTO = 10,
  parameter int unsigned LIMIAR_LONGE = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar,
  input  logic [11:0]         medida,
  input  logic                pronto,
  output logic                medir,
  output logic [MEDIA_W-1:0]  media,
  output logic                presenca,
  output logic                valido,
  output logic                erro,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int PER_W = $clog2(PERIODO) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  estado_t             estado_reg, estado_next;
  logic [PER_W-1:0]    periodo_cnt_reg, periodo_cnt_next;
  logic [TMO_W-1:0]    timeout_cnt_reg, timeout_cnt_next;
  logic [11:0]         medida_reg, medida_next;
  logic [MEDIA_W-1:0]  buffer_reg [N_AMOSTRAS];
  logic [1:0]          wr_ptr_reg, wr_ptr_next;
  logic [2:0]          fill_reg, fill_next;
  logic [SOMA_W-1:0]   soma_reg, soma_next;
  logic [MEDIA_W-1:0]  media_reg, media_next;
  logic                presenca_reg, presenca_next;
  logic                valido_reg, valido_next;
  logic                erro_reg, erro_next;
  logic                buf_we, buf_clr;
  logic [MEDIA_W-1:0]  binario, media_calc;
  logic                bcd_invalido;

  bcd3_para_binario u_bcd (
    .bcd      (medida_reg),
    .binario  (binario),
    .invalido (bcd_invalido)
  );

  assign media_calc = soma_reg[SOMA_W-1:2];

  // Next-state and datapath decisions; dropping `ligar` overrides everything.
  always_comb begin
    estado_next      = estado_reg;
    periodo_cnt_next = periodo_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    medida_next      = medida_reg;
    wr_ptr_next      = wr_ptr_reg;
    fill_next        = fill_reg;
    soma_next        = soma_reg;
    media_next       = media_reg;
    presenca_next    = presenca_reg;
    valido_next      = valido_reg;
    erro_next        = erro_reg;
    buf_we           = 1'b0;
    buf_clr          = 1'b0;

    // Period counter saturates so a long measurement still releases ESPERA.
    if (periodo_cnt_reg < PER_W'(PERIODO - 1))
      periodo_cnt_next = periodo_cnt_reg + 1'b1;

    case (estado_reg)
      INICIAL: if (ligar) estado_next = PEDE;
      PEDE: begin
        timeout_cnt_next = '0;
        // Counts cycles since this request, so PERIODO-1 lands on the next slot.
        periodo_cnt_next = PER_W'(1);
        estado_next      = AGUARDA;
      end
      AGUARDA: begin
        if (pronto) begin
          medida_next = medida;
          estado_next = ACUMULA;
        end else if (timeout_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
          erro_next   = 1'b1;
          estado_next = ERRO;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      ACUMULA: begin
        if (bcd_invalido) begin
          erro_next   = 1'b1;
          estado_next = ERRO;
        end else begin
          buf_we      = 1'b1;
          // Entry at wr_ptr is the oldest sample (or 0 while still filling).
          soma_next   = soma_reg - SOMA_W'(buffer_reg[wr_ptr_reg]) + SOMA_W'(binario);
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (fill_reg < 3'(N_AMOSTRAS)) fill_next = fill_reg + 1'b1;
          erro_next   = 1'b0;
          estado_next = AVALIA;
        end
      end
      AVALIA: begin
        if (fill_reg == 3'(N_AMOSTRAS)) begin
          media_next  = media_calc;
          valido_next = 1'b1;
          if (media_calc <= MEDIA_W'(LIMIAR_PERTO))
            presenca_next = 1'b1;
          else if (media_calc >= MEDIA_W'(LIMIAR_LONGE))
            presenca_next = 1'b0;
        end
        estado_next = ESPERA;
      end
      ESPERA: if (periodo_cnt_reg >= PER_W'(PERIODO - 1)) estado_next = PEDE;
      ERRO: begin
        erro_next   = 1'b1;
        estado_next = ESPERA;
      end
      default: estado_next = INICIAL;
    endcase

    if (!ligar) begin
      estado_next   = INICIAL;
      wr_ptr_next   = '0;
      fill_next     = '0;
      soma_next     = '0;
      media_next    = '0;
      presenca_next = 1'b0;
      valido_next   = 1'b0;
      erro_next     = 1'b0;
      buf_we        = 1'b0;
      buf_clr       = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg      <= INICIAL;
      periodo_cnt_reg <= '0;
      timeout_cnt_reg <= '0;
      medida_reg      <= '0;
      wr_ptr_reg      <= '0;
      fill_reg        <= '0;
      soma_reg        <= '0;
      media_reg       <= '0;
      presenca_reg    <= 1'b0;
      valido_reg      <= 1'b0;
      erro_reg        <= 1'b0;
    end else begin
      estado_reg      <= estado_next;
      periodo_cnt_reg <= periodo_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      medida_reg      <= medida_next;
      wr_ptr_reg      <= wr_ptr_next;
      fill_reg        <= fill_next;
      soma_reg        <= soma_next;
      media_reg       <= media_next;
      presenca_reg    <= presenca_next;
      valido_reg      <= valido_next;
      erro_reg        <= erro_next;
    end
  end

  // Circular sample buffer; cleared as a whole on reset or disable.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_AMOSTRAS; i++) begin
      if (reset || buf_clr)
        buffer_reg[i] <= '0;
      else if (buf_we && wr_ptr_reg == 2'(i))
        buffer_reg[i] <= binario;
    end
  end

  assign medir     = (estado_reg == PEDE);
  assign media     = media_reg;
  assign presenca  = presenca_reg;
  assign valido    = valido_reg;
  assign erro      = erro_reg;
  assign db_estado = estado_reg;

endmodule

// File: tb/tb_detector_presenca_hcsr04.sv
// Directed bench for detector_presenca_hcsr04: a table of sensor answers with
// expected averages/flags, plus hand-written reset, ignore and disable sequences.
module tb_detector_presenca_hcsr04;
  import detector_presenca_hcsr04_pkg::*;

  logic        clock = 1'b0;
  logic        reset, ligar, pronto;
  logic [11:0] medida;
  logic        medir, presenca, valido, erro;
  logic [9:0]  media;
  logic [3:0]  db_estado;

  detector_presenca_hcsr04 #(
    .PERIODO(100), .TIMEOUT(50), .LIMIAR_PERTO(10), .LIMIAR_LONGE(15)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .medida(medida),
    .pronto(pronto), .medir(medir), .media(media), .presenca(presenca),
    .valido(valido), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] medida;
    int          atraso;   // cycles from medir to pronto; 0 = never answer
    logic [9:0]  media;
    logic        valido;
    logic        presenca;
    logic        erro;
  } vec_t;

  vec_t tab[20];
  int checks = 0;
  int errors = 0;
  int ultimo_medir = 0;

  function automatic vec_t mk(logic [11:0] m, int a, logic [9:0] me,
                              logic v, logic p, logic e);
    vec_t r;
    r.medida = m; r.atraso = a; r.media = me;
    r.valido = v; r.presenca = p; r.erro = e;
    return r;
  endfunction

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  task automatic wait_medir(output int m, input int limite);
    bit achou = 0;
    m = -1;
    for (int i = 0; i < limite && !achou; i++) begin
      @(negedge clock);
      if (medir) begin
        achou = 1;
        m = cyc;
      end
    end
    chk("medir_chegou", 32'(achou), 32'd1);
  endtask

  // Answers one request and checks the outputs once the sample has settled.
  task automatic aplica(input vec_t v, input int idx, input int espaco, input int m_dado);
    int m;
    if (m_dado < 0) wait_medir(m, 250);
    else m = m_dado;
    if (espaco > 0) chk("espaco_medir", 32'(m - ultimo_medir), 32'(espaco));
    ultimo_medir = m;
    @(negedge clock);
    chk("medir_um_ciclo", 32'(medir), 32'd0);
    if (v.atraso == 0) begin
      repeat (49) @(negedge clock);
      chk("aguarda_antes_timeout", 32'(db_estado), 32'(AGUARDA));
      @(negedge clock);
      chk("estado_erro", 32'(db_estado), 32'(ERRO));
    end else begin
      repeat (v.atraso - 1) @(negedge clock);
      pronto = 1'b1;
      medida = v.medida;
      @(negedge clock);
      pronto = 1'b0;
      chk("estado_acumula", 32'(db_estado), 32'(ACUMULA));
      repeat (2) @(negedge clock);
      chk("estado_espera", 32'(db_estado), 32'(ESPERA));
    end
    chk("media", 32'(media), 32'(v.media));
    chk("valido", 32'(valido), 32'(v.valido));
    chk("presenca", 32'(presenca), 32'(v.presenca));
    chk("erro", 32'(erro), 32'(v.erro));
    $display("vec %0d medida=%03h atraso=%0d media=%0d valido=%0b presenca=%0b erro=%0b",
             idx, v.medida, v.atraso, media, valido, presenca, erro);
  endtask

  initial begin
    int m;
    int n_medir;

    // Hand-computed averages: buffer contents tracked oldest-first.
    tab[0]  = mk(12'h008, 20, 10'd0,   0, 0, 0);
    tab[1]  = mk(12'h008, 20, 10'd0,   0, 0, 0);
    tab[2]  = mk(12'h008, 20, 10'd0,   0, 0, 0);
    tab[3]  = mk(12'h008, 20, 10'd8,   1, 1, 0);
    tab[4]  = mk(12'h020, 20, 10'd11,  1, 1, 0);
    tab[5]  = mk(12'h020, 20, 10'd14,  1, 1, 0);
    tab[6]  = mk(12'h020, 20, 10'd17,  1, 0, 0);
    tab[7]  = mk(12'h020, 20, 10'd20,  1, 0, 0);
    tab[8]  = mk(12'h012, 20, 10'd18,  1, 0, 0);
    tab[9]  = mk(12'h012, 20, 10'd16,  1, 0, 0);
    tab[10] = mk(12'h012, 20, 10'd14,  1, 0, 0);
    tab[11] = mk(12'h012, 20, 10'd12,  1, 0, 0);
    tab[12] = mk(12'h000, 0,  10'd12,  1, 0, 1);  // timeout
    tab[13] = mk(12'h012, 20, 10'd12,  1, 0, 0);  // clears erro
    tab[14] = mk(12'h0A5, 20, 10'd12,  1, 0, 1);  // invalid BCD
    tab[15] = mk(12'h005, 50, 10'd10,  1, 1, 0);  // pronto on timeout cycle
    tab[16] = mk(12'h999, 20, 10'd257, 1, 0, 0);
    tab[17] = mk(12'h999, 20, 10'd503, 1, 0, 0);
    tab[18] = mk(12'h999, 20, 10'd750, 1, 0, 0);
    tab[19] = mk(12'h999, 20, 10'd999, 1, 0, 0);

    reset = 1'b1; ligar = 1'b0; pronto = 1'b0; medida = 12'h000;
    repeat (3) @(negedge clock);
    chk("rst_estado", 32'(db_estado), 32'(INICIAL));
    chk("rst_medir", 32'(medir), 32'd0);
    chk("rst_media", 32'(media), 32'd0);
    chk("rst_flags", {29'd0, valido, presenca, erro}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_estado", 32'(db_estado), 32'(INICIAL));
    chk("idle_medir", 32'(medir), 32'd0);

    ligar = 1'b1;
    for (int i = 0; i < 20; i++)
      aplica(tab[i], i, (i == 0) ? 0 : 100, -1);

    // pronto while in ESPERA must be ignored.
    pronto = 1'b1; medida = 12'h000;
    @(negedge clock);
    pronto = 1'b0;
    chk("espera_ignora_estado", 32'(db_estado), 32'(ESPERA));
    @(negedge clock);
    chk("espera_ignora_estado2", 32'(db_estado), 32'(ESPERA));
    chk("espera_ignora_media", 32'(media), 32'd999);
    $display("seq espera_pronto estado=%0d media=%0d", db_estado, media);

    // Disable in AGUARDA together with pronto, then a late pronto in INICIAL.
    wait_medir(m, 250);
    chk("espaco_medir", 32'(m - ultimo_medir), 32'd100);
    @(negedge clock);
    ligar = 1'b0; pronto = 1'b1; medida = 12'h008;
    @(negedge clock);
    chk("off_estado", 32'(db_estado), 32'(INICIAL));
    chk("off_media", 32'(media), 32'd0);
    chk("off_flags", {29'd0, valido, presenca, erro}, 32'd0);
    @(negedge clock);
    pronto = 1'b0;
    chk("off_pronto_tardio", 32'(db_estado), 32'(INICIAL));
    n_medir = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (medir) n_medir++;
    end
    chk("off_sem_medir", 32'(n_medir), 32'd0);
    $display("seq desliga estado=%0d media=%0d valido=%0b", db_estado, media, valido);

    // Re-enable: immediate request, then history must restart from empty.
    ligar = 1'b1;
    wait_medir(m, 2);
    aplica(mk(12'h008, 20, 10'd0, 0, 0, 0), 20, 0, m);
    aplica(mk(12'h008, 20, 10'd0, 0, 0, 0), 21, 100, -1);
    aplica(mk(12'h008, 20, 10'd0, 0, 0, 0), 22, 100, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
